// File: rtl/mycpu_wb_load_queue.sv
// In-order writeback stage: queues MEM instructions, pairs in-order data_sram responses with queued
// loads, extracts the addressed lane and registers the result for the regfile.
module mycpu_wb_load_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_mode,
  input  logic [DATA_W-1:0] req_alu,
  input  logic [DATA_W-1:0] req_rt,
  input  logic [REG_W-1:0]  req_dest,
  input  logic              req_wen,
  input  logic [31:0]       req_pc,
  input  logic              rdata_valid,
  output logic              rdata_ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_wen,
  output logic [31:0]       wb_pc,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic [5:0]        mode;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [REG_W-1:0]  dest;
    logic              wen;
    logic [31:0]       pc;
  } entry_t;

  entry_t             q [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   occ, load_cnt, drop_cnt;
  logic [CNT_W:0]     pending;
  logic               head_load, out_free, draining, drain_dec;
  logic               head_resp, complete, push, stray;
  logic [63:0]        rd64, lane, res64;
  logic [31:0]        m, rt32, merged;
  logic [OFF_W-1:0]   off;
  logic [1:0]         a;
  logic               sgn;
  logic [DATA_W-1:0]  result;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head      = q[rd_ptr];
    head_load = (occ != '0) && head.mode[5];
    out_free  = !wb_valid || wb_ready;
    draining  = (drop_cnt != '0);
    drain_dec = rdata_valid && draining;
    head_resp = rdata_valid && !draining && head_load && out_free;
    complete  = (occ != '0) && out_free && (!head.mode[5] || head_resp);
    stray     = rdata_valid && !draining && !head_load;
    pending   = {1'b0, occ} + {1'b0, drop_cnt};
    req_ready   = (pending < (CNT_W+1)'(DEPTH));
    rdata_ready = draining || (head_load && out_free);
    push      = req_valid && req_ready && !flush;
  end

  // Lane extraction for the head load, done in 64 bits and truncated to DATA_W.
  always_comb begin
    rd64   = 64'(rdata);
    off    = head.alu[OFF_W-1:0];
    a      = head.alu[1:0];
    sgn    = head.mode[0];
    lane   = rd64 >> {off, 3'b000};
    m      = (DATA_W == 64 && head.alu[2]) ? rd64[63:32] : rd64[31:0];
    rt32   = head.rt[31:0];
    merged = m;
    res64  = '0;
    if (head.mode[3:1] == 3'b011) begin
      case (a)
        2'd0:    merged = {m[7:0],  rt32[23:0]};
        2'd1:    merged = {m[15:0], rt32[15:0]};
        2'd2:    merged = {m[23:0], rt32[7:0]};
        default: merged = m;
      endcase
    end else if (head.mode[3:1] == 3'b100) begin
      case (a)
        2'd0:    merged = m;
        2'd1:    merged = {rt32[31:24], m[31:8]};
        2'd2:    merged = {rt32[31:16], m[31:16]};
        default: merged = {rt32[31:8],  m[31:24]};
      endcase
    end
    case (head.mode[3:1])
      3'b000:         res64 = {{56{sgn & lane[7]}},  lane[7:0]};
      3'b001:         res64 = {{48{sgn & lane[15]}}, lane[15:0]};
      3'b010:         res64 = {{32{sgn & lane[31]}}, lane[31:0]};
      3'b011, 3'b100: res64 = {{32{merged[31]}}, merged};
      3'b101:         res64 = (DATA_W == 64) ? rd64 : 64'd0;
      default:        res64 = '0;
    endcase
    result = head.mode[5] ? res64[DATA_W-1:0] : head.alu;
  end

  // NOTE: queue storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{req_mode, req_alu, req_rt, req_dest, req_wen, req_pc};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      load_cnt <= '0;
      drop_cnt <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dest  <= '0;
      wb_wen   <= 1'b0;
      wb_pc    <= '0;
      err      <= 1'b0;
    end else begin
      if (stray) err <= 1'b1;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
        load_cnt <= '0;
        // Loads still in the queue owe a response; one answered this very cycle does not.
        drop_cnt <= drop_cnt + load_cnt - CNT_W'(drain_dec) - CNT_W'(head_resp);
        wb_valid <= 1'b0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + 1'b1;
        if (complete) rd_ptr <= rd_ptr + 1'b1;
        occ      <= occ + CNT_W'(push) - CNT_W'(complete);
        load_cnt <= load_cnt + CNT_W'(push && req_mode[5]) - CNT_W'(complete && head.mode[5]);
        drop_cnt <= drop_cnt - CNT_W'(drain_dec);
        if (complete) begin
          wb_valid <= 1'b1;
          wb_data  <= result;
          wb_dest  <= head.dest;
          wb_wen   <= head.wen;
          wb_pc    <= head.pc;
        end else if (wb_ready) begin
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mycpu_wb_load_queue.sv
// Directed bench for mycpu_wb_load_queue (DATA_W=32, DEPTH=2): extraction, backpressure, flush, errors.
module tb_mycpu_wb_load_queue;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req_valid, req_ready;
  logic [5:0]  req_mode;
  logic [31:0] req_alu, req_rt;
  logic [4:0]  req_dest;
  logic        req_wen;
  logic [31:0] req_pc;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_wen;
  logic [31:0] wb_pc;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] M_ALU = 6'b000000;
  localparam logic [5:0] M_LB  = 6'b100001;
  localparam logic [5:0] M_LBU = 6'b100000;
  localparam logic [5:0] M_LH  = 6'b100011;
  localparam logic [5:0] M_LHU = 6'b100010;
  localparam logic [5:0] M_LW  = 6'b100101;
  localparam logic [5:0] M_LWL = 6'b100110;
  localparam logic [5:0] M_LWR = 6'b101000;

  mycpu_wb_load_queue #(.DATA_W(32), .DEPTH(2), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_alu(req_alu), .req_rt(req_rt), .req_dest(req_dest), .req_wen(req_wen), .req_pc(req_pc),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_wen(wb_wen), .wb_pc(wb_pc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single rising edge; returns just after the following falling edge.
  task automatic push_req(input logic [5:0] mode, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [4:0] dest, input logic [31:0] pc);
    req_valid = 1'b1; req_mode = mode; req_alu = alu; req_rt = rt;
    req_dest = dest; req_wen = 1'b1; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [5:0] mode, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    push_req(mode, alu, rt, 5'd3, 32'h200);
    check({tag, "_pre_wb"}, 64'(wb_valid), 64'd0);
    rdata_valid = 1'b1; rdata = rd;
    #1 check({tag, "_rready"}, 64'(rdata_ready), 64'd1);
    @(negedge clk);
    rdata_valid = 1'b0;
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, "_data"}, 64'(wb_data), 64'(exp));
    @(negedge clk);
    check({tag, "_retired"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_mode = '0; req_alu = '0; req_rt = '0;
    req_dest = '0; req_wen = 1'b0; req_pc = '0; rdata_valid = 1'b0; rdata = '0; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata_ready", 64'(rdata_ready), 64'd0);
    reset = 1'b0;
    #1 check("rst_req_ready", 64'(req_ready), 64'd1);

    // Non-load: result appears after the second rising edge.
    push_req(M_ALU, 32'h1234, 32'h0, 5'd8, 32'h100);
    check("alu_latency", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("alu_wb_valid", 64'(wb_valid), 64'd1);
    check("alu_data", 64'(wb_data), 64'h1234);
    check("alu_dest", 64'(wb_dest), 64'd8);
    check("alu_wen", 64'(wb_wen), 64'd1);
    check("alu_pc", 64'(wb_pc), 64'h100);
    @(negedge clk);
    check("alu_retired", 64'(wb_valid), 64'd0);

    // Extraction
    do_load("lb",    M_LB,  32'h1002, 32'h0,        32'h80FF0011, 32'hFFFFFFFF);
    do_load("lbu",   M_LBU, 32'h1002, 32'h0,        32'h80FF0011, 32'h000000FF);
    do_load("lh",    M_LH,  32'h1002, 32'h0,        32'h80FF0011, 32'hFFFF80FF);
    do_load("lhu",   M_LHU, 32'h1002, 32'h0,        32'h80FF0011, 32'h000080FF);
    do_load("lb3",   M_LB,  32'h1003, 32'h0,        32'h80FF0011, 32'hFFFFFF80);
    do_load("lw",    M_LW,  32'h1000, 32'h0,        32'h80FF0011, 32'h80FF0011);
    do_load("lwl1",  M_LWL, 32'h1001, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
    do_load("lwl3",  M_LWL, 32'h1003, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
    do_load("lwr2",  M_LWR, 32'h1002, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
    do_load("lwr3",  M_LWR, 32'h1003, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);

    // Backpressure: two loads fill the queue, output stalls, then drains in order.
    wb_ready = 1'b0;
    push_req(M_LW, 32'h0, 32'h0, 5'd1, 32'h300);
    push_req(M_LW, 32'h8, 32'h0, 5'd2, 32'h304);
    #1 check("full_req_ready", 64'(req_ready), 64'd0);
    rdata_valid = 1'b1; rdata = 32'hDEADBEEF;
    #1 check("bp_rready1", 64'(rdata_ready), 64'd1);
    @(negedge clk);
    rdata = 32'h01020304;
    check("bp_wb1", 64'(wb_data), 64'hDEADBEEF);
    #1 check("bp_stalled_rready", 64'(rdata_ready), 64'd0);
    @(negedge clk);
    check("bp_hold_valid", 64'(wb_valid), 64'd1);
    check("bp_hold_data", 64'(wb_data), 64'hDEADBEEF);
    check("bp_hold_pc", 64'(wb_pc), 64'h300);
    wb_ready = 1'b1;
    #1 check("bp_rready2", 64'(rdata_ready), 64'd1);
    @(negedge clk);
    rdata_valid = 1'b0;
    check("bp_wb2_valid", 64'(wb_valid), 64'd1);
    check("bp_wb2_data", 64'(wb_data), 64'h01020304);
    check("bp_wb2_dest", 64'(wb_dest), 64'd2);
    @(negedge clk);
    check("bp_drained", 64'(wb_valid), 64'd0);

    // Flush with two loads queued: both responses are swallowed.
    push_req(M_LW, 32'h0, 32'h0, 5'd4, 32'h400);
    push_req(M_LW, 32'h4, 32'h0, 5'd5, 32'h404);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("fl_wb_valid", 64'(wb_valid), 64'd0);
    check("fl_req_ready", 64'(req_ready), 64'd0);
    check("fl_rready", 64'(rdata_ready), 64'd1);
    rdata_valid = 1'b1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("fl_drop1_wb", 64'(wb_valid), 64'd0);
    #1 check("fl_drop1_req_ready", 64'(req_ready), 64'd1);
    check("fl_drop1_rready", 64'(rdata_ready), 64'd1);
    @(negedge clk);
    rdata_valid = 1'b0;
    #1 check("fl_drop2_wb", 64'(wb_valid), 64'd0);
    check("fl_drop2_rready", 64'(rdata_ready), 64'd0);
    check("fl_drop2_err", 64'(err), 64'd0);

    // Flush clears a stalled result and drops a simultaneous push.
    wb_ready = 1'b0;
    push_req(M_ALU, 32'h77, 32'h0, 5'd6, 32'h500);
    @(negedge clk);
    check("flo_wb_before", 64'(wb_valid), 64'd1);
    flush = 1'b1; req_valid = 1'b1; req_mode = M_ALU; req_alu = 32'h99;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; wb_ready = 1'b1;
    check("flo_wb_cleared", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check("flo_push_dropped", 64'(wb_valid), 64'd0);

    // Flush coinciding with the head's response: consumed, not owed, no result.
    push_req(M_LW, 32'h0, 32'h0, 5'd7, 32'h600);
    rdata_valid = 1'b1; rdata = 32'h5A5A5A5A; flush = 1'b1;
    #1 check("flr_rready", 64'(rdata_ready), 64'd1);
    @(negedge clk);
    rdata_valid = 1'b0; flush = 1'b0;
    #1 check("flr_wb", 64'(wb_valid), 64'd0);
    check("flr_no_drop", 64'(rdata_ready), 64'd0);
    check("flr_req_ready", 64'(req_ready), 64'd1);
    check("flr_err", 64'(err), 64'd0);
    push_req(M_ALU, 32'h55, 32'h0, 5'd9, 32'h604);
    @(negedge clk);
    check("flr_after_data", 64'(wb_data), 64'h55);
    @(negedge clk);

    // Stray response with an empty queue: sticky error, no writeback.
    rdata_valid = 1'b1; rdata = 32'h12345678;
    #1 check("err_rready", 64'(rdata_ready), 64'd0);
    @(negedge clk);
    rdata_valid = 1'b0;
    check("err_set", 64'(err), 64'd1);
    check("err_no_wb", 64'(wb_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    reset = 1'b1;
    #1 check("err_cleared", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
